mig_app_mem_responder: RTL
==========================

Name: mig_app_mem_responder

Overview:
Synthesizable behavioural stand-in for the MIG 7-series DDR3 controller user (app_*) interface, backed by on-chip RAM.
It answers the app-side commands that the demo system's memory adapter issues.
This lets system-level sims run without the PHY and DDR3 chip model, and supports fast FPGA bring-up.
It reproduces calibration delay, the app_rdy/app_wdf_rdy handshakes, in-order fixed-latency read return and byte-masked writes.

Parameters:
addr_width_p, 28, app_addr width
data_width_p, 128, app data width (DQ16 x BL8)
addr_lsb_p, 3, app_addr low bits dropped to form the word index
mem_els_p, 1024, RAM depth in words; the word index wraps modulo mem_els_p
read_latency_p, 4, cycles from read issue to app_rd_data_valid (>=1)
calib_cycles_p, 200, cycles after reset before init_calib_complete_o is asserted
fifo_els_p, 4, depth of the command FIFO and the write-data FIFO
throttle_period_p, 0, if nonzero, app_rdy_o is forced low one cycle in every throttle_period_p cycles

Ports:
clk_i  in  1  sole clock
reset_active_low_i  in  1  asynchronous active-low reset
app_addr_i  in  addr_width_p  command address
app_cmd_i  in  3  3'b000 = write, 3'b001 = read, all other codes are illegal
app_en_i  in  1  command valid
app_rdy_o  out  1  command ready
app_wdf_data_i  in  data_width_p  write data
app_wdf_mask_i  in  data_width_p/8  byte mask; 1 = do NOT write that byte
app_wdf_wren_i  in  1  write data valid
app_wdf_end_i  in  1  last beat; always 1 for BL8 on a 4:1 UI
app_wdf_rdy_o  out  1  write data ready
app_rd_data_o  out  data_width_p  read data
app_rd_data_valid_o  out  1  read data valid
app_rd_data_end_o  out  1  equals app_rd_data_valid_o
init_calib_complete_o  out  1  calibration done
error_o  out  1  sticky protocol error

Behaviour:
- Reset (async assert, synchronous release):
  - all outputs 0
  - FIFOs empty, read pipeline flushed
  - calib counter = 0
  - RAM contents undefined; they are not cleared
- Calibration:
  - the counter increments each cycle until it reaches calib_cycles_p
  - init_calib_complete_o is then 1 and stays 1 until reset
  - while calibrating, app_rdy_o = app_wdf_rdy_o = 0
- Command accept:
  - a command is accepted when app_en_i & app_rdy_o; its {cmd, word index} is pushed to the command FIFO
  - app_rdy_o = calibrated & !cmd_fifo_full & !throttle_slot
  - the throttle slot is high when a free-running counter modulo throttle_period_p equals period-1
- Write data accept:
  - write data is accepted when app_wdf_wren_i & app_wdf_rdy_o; {data, mask} is pushed to the write-data FIFO
  - app_wdf_rdy_o = calibrated & !wdf_full
  - write data may arrive before, with, or after its command; pairing is strictly FIFO order
  - app_wdf_wren_i with app_wdf_end_i = 0 sets error_o; the beat is still accepted
- Execution: the head of the command FIFO is processed in order, at most one command per cycle.
  - Write head: retires only when the write-data FIFO is non-empty. In that cycle it pops both FIFOs and writes each byte whose mask bit is 0. If no data is present, it stalls. Later reads are blocked behind it, which guarantees read-after-write ordering.
  - Read head: pops, reads RAM, and enters a read_latency_p-stage valid/data shift pipeline. app_rd_data_valid_o pulses exactly read_latency_p cycles after the pop cycle. Back-to-back reads give back-to-back valid cycles. Data returns in issue order; there is no backpressure on read data.
  - Illegal cmd head: pops with no RAM access and sets error_o.
- Same-cycle events:
  - push and pop on a full FIFO is not allowed, because ready is computed from the registered full flag
  - push and pop on an empty FIFO goes through the normal latency; there is no bypass
  - a write to address A followed by a read of A in the next cycle returns the new data
- Word index = app_addr_i[addr_lsb_p +: $clog2(mem_els_p)]; higher address bits are ignored (aliasing).
- Reset asserted mid-operation:
  - in-flight reads are dropped; no valid is produced after reset
  - pending writes are discarded
  - calibration restarts from zero

Test Plan:
- Reset, then idle 199 cycles -> init_calib_complete_o=0 and app_rdy_o=0 throughout; cycle 200 -> both 1.
- Write addr 0x40, data 0x0123..CDEF, mask 0, then read 0x40 -> app_rd_data_valid_o exactly 4 cycles after the read pops; data matches; data_end=1.
- Write 0xFF..FF to 0x80, then write 0x00..00 to 0x80 with mask 16'h00FF, then read 0x80 -> upper 8 bytes 0x00, lower 8 bytes 0xFF.
- 3 write-data beats issued before any command, then 3 write cmds (0x0, 0x8, 0x10), then 3 reads -> the beats pair in order; 3 consecutive valid cycles return the matching data.
- Stall write data with 4 reads queued behind a write cmd -> app_rdy_o drops when the cmd FIFO holds 4; no read valid appears until data arrives; reads then return in order.
- Assert reset 2 cycles after issuing a read -> no app_rd_data_valid_o ever pulses; after recalibration, throttle_period_p=5 shows app_rdy_o low 1 of every 5 cycles; app_cmd_i=3'b010 -> error_o=1 and stays 1.

Source files
------------

// File: rtl/mig_app_mem_responder.sv
// rtl/mig_app_mem_responder.sv - RAM-backed stand-in for the MIG 7-series DDR3 app interface
// Commands and write beats queue independently and are paired in FIFO order at execution.
module mig_app_mem_responder #(
  parameter int addr_width_p      = 28,
  parameter int data_width_p      = 128,
  parameter int addr_lsb_p        = 3,
  parameter int mem_els_p         = 1024,
  parameter int read_latency_p    = 4,
  parameter int calib_cycles_p    = 200,
  parameter int fifo_els_p        = 4,
  parameter int throttle_period_p = 0
) (
  input  logic                      clk_i,
  input  logic                      reset_active_low_i,
  input  logic [addr_width_p-1:0]   app_addr_i,
  input  logic [2:0]                app_cmd_i,
  input  logic                      app_en_i,
  output logic                      app_rdy_o,
  input  logic [data_width_p-1:0]   app_wdf_data_i,
  input  logic [data_width_p/8-1:0] app_wdf_mask_i,
  input  logic                      app_wdf_wren_i,
  input  logic                      app_wdf_end_i,
  output logic                      app_wdf_rdy_o,
  output logic [data_width_p-1:0]   app_rd_data_o,
  output logic                      app_rd_data_valid_o,
  output logic                      app_rd_data_end_o,
  output logic                      init_calib_complete_o,
  output logic                      error_o
);
  localparam int IW   = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam int MW   = data_width_p / 8;
  localparam int CW   = $clog2(calib_cycles_p + 1);
  localparam int FW   = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int CNTW = FW + 1;
  localparam int QW   = IW + 3;
  localparam int DQW  = data_width_p + MW;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  logic [CW-1:0]           r_calib_cnt;
  logic [QW-1:0]           r_cmd_q [fifo_els_p];
  logic [FW-1:0]           r_cmd_wp, r_cmd_rp;
  logic [CNTW-1:0]         r_cmd_cnt;
  logic [DQW-1:0]          r_wdf_q [fifo_els_p];
  logic [FW-1:0]           r_wdf_wp, r_wdf_rp;
  logic [CNTW-1:0]         r_wdf_cnt;
  logic [data_width_p-1:0] r_mem [mem_els_p];
  logic [read_latency_p-1:0] r_rd_vld;
  logic [data_width_p-1:0] r_rd_data [read_latency_p];
  logic                    r_error;

  logic            w_calib, w_throttle;
  logic            w_cmd_push, w_cmd_pop, w_wdf_push, w_wdf_pop;
  logic            w_mem_we, w_rd_issue, w_illegal;
  logic [QW-1:0]   w_cmd_head;
  logic [DQW-1:0]  w_wdf_head;
  logic [IW-1:0]   w_head_idx, w_push_idx;
  logic            w_unused_addr;

  function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
    return (p == FW'(fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_calib = (r_calib_cnt == CW'(calib_cycles_p));

  always_ff @(posedge clk_i or negedge reset_active_low_i) begin
    if (!reset_active_low_i) r_calib_cnt <= '0;
    else if (!w_calib)       r_calib_cnt <= r_calib_cnt + 1'b1;
  end

  generate
    if (throttle_period_p > 0) begin : g_thr
      localparam int TW = (throttle_period_p > 1) ? $clog2(throttle_period_p) : 1;
      logic [TW-1:0] r_thr_cnt;
      assign w_throttle = (r_thr_cnt == TW'(throttle_period_p - 1));
      always_ff @(posedge clk_i or negedge reset_active_low_i) begin
        if (!reset_active_low_i) r_thr_cnt <= '0;
        else if (w_throttle)     r_thr_cnt <= '0;
        else                     r_thr_cnt <= r_thr_cnt + 1'b1;
      end
    end else begin : g_no_thr
      assign w_throttle = 1'b0;
    end
  endgenerate

  assign app_rdy_o     = w_calib & (r_cmd_cnt != CNTW'(fifo_els_p)) & ~w_throttle;
  assign app_wdf_rdy_o = w_calib & (r_wdf_cnt != CNTW'(fifo_els_p));
  assign w_cmd_push    = app_en_i & app_rdy_o;
  assign w_wdf_push    = app_wdf_wren_i & app_wdf_rdy_o;
  assign w_push_idx    = app_addr_i[addr_lsb_p +: IW];
  assign w_unused_addr = ^app_addr_i;
  assign w_cmd_head    = r_cmd_q[r_cmd_rp];
  assign w_head_idx    = w_cmd_head[IW-1:0];
  assign w_wdf_head    = r_wdf_q[r_wdf_rp];

  // A write head waits for its data beat, which keeps later reads ordered behind it.
  always_comb begin
    w_cmd_pop  = 1'b0;
    w_wdf_pop  = 1'b0;
    w_mem_we   = 1'b0;
    w_rd_issue = 1'b0;
    w_illegal  = 1'b0;
    if (r_cmd_cnt != '0) begin
      case (w_cmd_head[QW-1 -: 3])
        CMD_WR: begin
          if (r_wdf_cnt != '0) begin
            w_cmd_pop = 1'b1;
            w_wdf_pop = 1'b1;
            w_mem_we  = 1'b1;
          end
        end
        CMD_RD: begin
          w_cmd_pop  = 1'b1;
          w_rd_issue = 1'b1;
        end
        default: begin
          w_cmd_pop = 1'b1;
          w_illegal = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_active_low_i) begin
    if (!reset_active_low_i) begin
      r_cmd_wp  <= '0;
      r_cmd_rp  <= '0;
      r_cmd_cnt <= '0;
      r_wdf_wp  <= '0;
      r_wdf_rp  <= '0;
      r_wdf_cnt <= '0;
      r_error   <= 1'b0;
      r_rd_vld  <= '0;
      for (int i = 0; i < read_latency_p; i++) r_rd_data[i] <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wp <= ptr_inc(r_cmd_wp);
      if (w_cmd_pop)  r_cmd_rp <= ptr_inc(r_cmd_rp);
      if (w_wdf_push) r_wdf_wp <= ptr_inc(r_wdf_wp);
      if (w_wdf_pop)  r_wdf_rp <= ptr_inc(r_wdf_rp);
      r_cmd_cnt <= r_cmd_cnt + {{FW{1'b0}}, w_cmd_push} - {{FW{1'b0}}, w_cmd_pop};
      r_wdf_cnt <= r_wdf_cnt + {{FW{1'b0}}, w_wdf_push} - {{FW{1'b0}}, w_wdf_pop};
      if (w_illegal | (w_wdf_push & ~app_wdf_end_i)) r_error <= 1'b1;
      r_rd_vld[0]  <= w_rd_issue;
      r_rd_data[0] <= w_rd_issue ? r_mem[w_head_idx] : '0;
      for (int i = 1; i < read_latency_p; i++) begin
        r_rd_vld[i]  <= r_rd_vld[i-1];
        r_rd_data[i] <= r_rd_data[i-1];
      end
    end
  end

  // Storage only: queue payloads and RAM contents are never cleared.
  always_ff @(posedge clk_i) begin
    if (w_cmd_push) r_cmd_q[r_cmd_wp] <= {app_cmd_i, w_push_idx};
    if (w_wdf_push) r_wdf_q[r_wdf_wp] <= {app_wdf_data_i, app_wdf_mask_i};
    if (w_mem_we) begin
      for (int b = 0; b < MW; b++) begin
        if (!w_wdf_head[b]) r_mem[w_head_idx][b*8 +: 8] <= w_wdf_head[MW + b*8 +: 8];
      end
    end
  end

  assign app_rd_data_o         = r_rd_data[read_latency_p-1];
  assign app_rd_data_valid_o   = r_rd_vld[read_latency_p-1];
  assign app_rd_data_end_o     = r_rd_vld[read_latency_p-1];
  assign init_calib_complete_o = w_calib;
  assign error_o               = r_error;
endmodule
